// File: rtl/shift_seq.sv
// shift_seq: sequential 32-bit barrel-free shifter.
// One bit per SHIFT cycle by default; defining SHIFT_SEQ_DOUBLE_STEP_EN
// moves two bits per cycle while at least two remain (results unchanged,
// latency roughly halved).
module shift_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] i,
    input  logic [4:0]  amt,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] o,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    typedef struct packed {
        logic right;
        logic arith;
    } mode_t;

    state_t      state, state_nxt;
    mode_t       mode;
    logic [31:0] work, work_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        last_step;

    // single-bit step; the right-shift fill is the old MSB only when arithmetic
    function automatic logic [31:0] step1(input logic [31:0] w, input mode_t m);
        if (m.right)
            return {m.arith & w[31], w[31:1]};
        else
            return {w[30:0], 1'b0};
    endfunction

    // next working value / counter for one SHIFT cycle
    always_comb begin
        work_nxt  = step1(work, mode);
        cnt_nxt   = cnt - 5'd1;
        last_step = (cnt == 5'd1);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        if (cnt >= 5'd2) begin
            work_nxt = step1(step1(work, mode), mode);
            cnt_nxt  = cnt - 5'd2;
        end
        // SHIFT is only entered with cnt >= 1, so <= 2 means this step empties it
        last_step = (cnt <= 5'd2);
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state and status decode
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (amt == 5'd0) ? FIN : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_step) state_nxt = FIN;
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: capture on accept, step while shifting, publish on entry to FIN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work <= '0;
            cnt  <= '0;
            mode <= '0;
            o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work       <= i;
                        cnt        <= amt;
                        mode.right <= right;
                        mode.arith <= arith;
                        if (amt == 5'd0) o <= i;
                    end
                end
                SHIFT: begin
                    work <= work_nxt;
                    cnt  <= cnt_nxt;
                    if (last_step) o <= work_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboarded bench for shift_seq: the driver pushes the expected result,
// DONE cycle and busy length at issue time; a monitor pops on every DONE.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] i = '0;
    logic [4:0]  amt = '0;
    logic        right = 1'b0;
    logic        arith = 1'b0;
    logic [31:0] o;
    logic        busy;
    logic        done;

    shift_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .i(i), .amt(amt),
        .right(right), .arith(arith), .o(o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] o;
        int          cyc;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference: plain shift operators
    function automatic logic [31:0] model(input logic [31:0] d, input int a,
                                          input logic r, input logic ar);
        logic signed [31:0] s;
        s = d;
        if (!r)  return d << a;
        if (ar)  return 32'(s >>> a);
        return d >> a;
    endfunction

    // edges after the accepting edge until DONE is visible
    function automatic int lat(input int a);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        return (a + 1) / 2;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    initial begin
        int busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_run++;
            else               busy_run = 0;
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: o=%h cyc=%0d, no operation pending", o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", o, e.o);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_len", 32'(busy_run), 32'(e.busy_len));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // issue one request from an idle cycle; scramble inputs after acceptance
    task automatic issue(input logic [31:0] d, input int a, input logic r, input logic ar);
        wait_idle();
        i = d; amt = 5'(a); right = r; arith = ar; start = 1'b1;
        sb.push_back('{model(d, a, r, ar), cyc + 1 + lat(a), lat(a) + 1});
        @(negedge clk);
        start = 1'b0;
        i = $urandom; amt = 5'($urandom); right = 1'($urandom); arith = 1'($urandom);
    endtask

    // two requests with START held through FIN of the first
    task automatic b2b(input logic [31:0] d1, input int a1, input logic r1, input logic ar1,
                       input logic [31:0] d2, input int a2, input logic r2, input logic ar2);
        int acc2;
        wait_idle();
        i = d1; amt = 5'(a1); right = r1; arith = ar1; start = 1'b1;
        sb.push_back('{model(d1, a1, r1, ar1), cyc + 1 + lat(a1), lat(a1) + 1});
        acc2 = cyc + 1 + lat(a1) + 2;
        sb.push_back('{model(d2, a2, r2, ar2), acc2 + lat(a2), lat(a2) + 1});
        @(negedge clk);
        i = d2; amt = 5'(a2); right = r2; arith = ar2;
        repeat (lat(a1) + 2) @(negedge clk);
        start = 1'b0;
        i = $urandom; amt = 5'($urandom);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("reset_o", o, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        reset_n = 1'b1;

        // directed vectors
        issue(32'h80000001, 4, 1'b1, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_o", o, 32'hF8000000);
        issue(32'h80000001, 4, 1'b1, 1'b0);
        issue(32'h00000001, 31, 1'b0, 1'b0);
        issue(32'h12345678, 0, 1'b0, 1'b0);
        issue(32'h80000000, 5, 1'b1, 1'b1);
        drain();

        // START during SHIFT must be ignored
        d0 = done_cnt;
        issue(32'h0000F00F, 8, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        i = 32'hFFFFFFFF; amt = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        chk("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
        chk("ignored_start_o", o, 32'h00F00F00);

        // reset mid-operation
        issue(32'hA5A5A5A5, 20, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_o", o, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // back-to-back throughput
        b2b(32'hDEADBEEF, 3, 1'b1, 1'b1, 32'h0F0F0F0F, 0, 1'b0, 1'b0);
        b2b(32'h80000000, 0, 1'b1, 1'b1, 32'hCAFEF00D, 7, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            b2b($urandom, $urandom_range(0, 31), 1'($urandom), 1'($urandom),
                $urandom, $urandom_range(0, 31), 1'($urandom), 1'($urandom));
        drain();

        // random traffic with occasional extreme distances
        for (int k = 0; k < 40; k++) begin
            int a;
            case ($urandom_range(0, 5))
                0:       a = 0;
                1:       a = 31;
                default: a = $urandom_range(0, 31);
            endcase
            issue($urandom, a, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits and the shift amount at 5 bits.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RESET_N  input  1  reset, synchronous and active-low, sampled on the rising edge of CLK.
REQ-004 START  input  1  request strobe, sampled only while BUSY=0.
REQ-005 I  input  32  operand, captured on the accepted START edge.
REQ-006 AMT  input  5  shift distance 0..31, captured on the accepted START edge.
REQ-007 RIGHT  input  1  1=right shift, 0=left shift; captured with I.
REQ-008 ARITH  input  1  right shifts only: 1=sign-fill from bit 31, 0=zero-fill; ignored for left shifts; captured with I.
REQ-009 O  output  32  result register.
REQ-010 BUSY  output  1  high while an operation is in progress.
REQ-011 DONE  output  1  one-cycle pulse marking O valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and FIN.
REQ-013 In IDLE with START=1, the block SHALL load I into a working register and AMT into a down-counter, latch RIGHT and ARITH, and enter FIN if AMT=0, otherwise SHIFT.
REQ-014 Each SHIFT cycle SHALL move the working register one bit and decrement the counter; the state SHALL become FIN on the edge where the counter goes from 1 to 0.
REQ-015 A left step SHALL shift bits 30:0 into bits 31:1 and insert 0 at bit 0.
REQ-016 A right step SHALL shift bits 31:1 into bits 30:0 and fill bit 31 with the old bit 31 when ARITH=1, or with 0 when ARITH=0.
REQ-017 O SHALL be loaded from the final working-register value on the edge entering FIN and SHALL hold that value until the next load or reset.
REQ-018 DONE SHALL be 1 only in FIN; FIN SHALL return to IDLE on the next edge unconditionally.
REQ-019 BUSY SHALL be 1 in SHIFT and FIN, and 0 in IDLE.
REQ-020 START SHALL be ignored while BUSY=1; a request held through FIN SHALL be accepted on the first IDLE cycle.
REQ-021 Changes on I, AMT, RIGHT or ARITH after acceptance SHALL have no effect on the operation in flight.
REQ-022 Latency: DONE SHALL assert AMT+1 rising edges after the accepting edge (1 edge for AMT=0).
REQ-023 Back-to-back throughput SHALL be one operation per AMT+2 cycles.

Reset
REQ-024 RESET_N=0 at a rising edge SHALL force IDLE, O=0, BUSY=0, DONE=0 and clear the counter and working register, including mid-operation; no DONE pulse SHALL follow an aborted operation.
REQ-025 Reset SHALL take priority over START on the same edge.

Configuration
REQ-026 When macro SHIFT_SEQ_DOUBLE_STEP_EN is defined, each SHIFT cycle SHALL move two bits (same fill rules per bit) while the counter is 2 or more, and one bit when it is 1; the counter SHALL decrement accordingly.
REQ-027 With SHIFT_SEQ_DOUBLE_STEP_EN defined, DONE SHALL assert ceil(AMT/2)+1 edges after acceptance; results SHALL be bit-identical to the macro-undefined build.
REQ-028 Without SHIFT_SEQ_DOUBLE_STEP_EN, the block SHALL perform only single-bit steps as in REQ-014 to REQ-016.

Verification
REQ-029 I=0x80000001, AMT=4, RIGHT=1, ARITH=1 -> DONE on the 5th edge after acceptance, O=0xF8000000, BUSY high for 5 cycles.
REQ-030 Same operand, ARITH=0 -> O=0x08000000; then I=0x00000001, AMT=31, RIGHT=0 -> O=0x80000000, DONE 32 edges after acceptance.
REQ-031 I=0x12345678, AMT=0 -> DONE 1 edge after acceptance, O=0x12345678.
REQ-032 START pulsed with I=0xFFFFFFFF during SHIFT of an AMT=8 op -> request ignored, O equals the first operation's result, and exactly one DONE pulse.
REQ-033 RESET_N=0 for one edge during SHIFT -> next cycle O=0, BUSY=0, DONE=0, and no DONE pulse for 40 cycles without a new START.
REQ-034 With SHIFT_SEQ_DOUBLE_STEP_EN: I=0x80000000, AMT=5, RIGHT=1, ARITH=1 -> DONE 4 edges after acceptance, O=0xFC000000.
